exc_ctrl: RTL and testbench
===========================

# exc_ctrl

Exception controller for the interrupt-capable pipelined CPU. It consumes the filtered arithmetic-overflow flag and, optionally, an external interrupt, both for the instruction in EX. It squashes the faulting instruction, saves its PC into EPC and flushes the pipeline, then redirects fetch to the handler. It also services `eret` and holds the CP0 Status/Cause/EPC registers.

## Interface
- `HANDLER_ADDR`, default 32'h0000_0080: exception/interrupt vector.
- `clk` in 1: sole clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ovf_i` in 1: overflow already qualified to add/sub in EX.
- `ex_valid_i` in 1: EX holds a real instruction, not a bubble.
- `pc_ex_i` in 32: PC of the EX instruction.
- `eret_i` in 1: EX instruction is `eret`.
- `int_i` in 1: external interrupt, level, asynchronous to `clk`.
- `mtc0_i` in 1: EX instruction is `mtc0`.
- `cp0_addr_i` in 5: CP0 register number.
- `cp0_wdata_i` in 32: `mtc0` data.
- `cp0_rdata_o` out 32: combinational read of `cp0_addr_i`.
- `kill_o` out 1: combinational; suppress EX result writeback.
- `flush_o` out 1: clear IF/ID/EX pipeline registers.
- `redirect_o` out 1: load PC from `redirect_pc_o`.
- `redirect_pc_o` out 32: redirect target.
- `busy_o` out 1: FSM not in IDLE.

## Operation
- CP0 registers; reset value of all three is 0:
  - Status (12): bit0 IE, bit1 EXL; other bits read 0.
  - Cause (13): [6:2] ExcCode, bit10 IP (synchronized `int_i`). Read-only to `mtc0`.
  - EPC (14): full 32 bits.
  - Any other address reads 0.
- `kill_o` = `ovf_i & ex_valid_i`, in every state and regardless of EXL. An overflowing add/sub never writes back.
- Events are accepted only in IDLE with `ex_valid_i`=1. Priority, highest first:
  1. Overflow: requires EXL=0. EPC←`pc_ex_i`, ExcCode←12, EXL←1, go to FLUSH.
  2. Interrupt: requires IE=1, EXL=0 and IP=1. EPC←`pc_ex_i` (EX instruction is squashed and re-executed after return), ExcCode←0, EXL←1, go to FLUSH.
  3. `eret`: EXL←0, go to RETURN.
  4. `mtc0`: write Status[1:0] or EPC.
- An overflow with EXL=1 is killed but not vectored. EPC and Cause are unchanged.
- FSM states:
  - IDLE: `flush_o`=0, `redirect_o`=0.
  - FLUSH: `flush_o`=1. Always goes to VECTOR.
  - VECTOR: `flush_o`=1, `redirect_o`=1, `redirect_pc_o`=`HANDLER_ADDR`. Goes to IDLE.
  - RETURN: `flush_o`=1, `redirect_o`=1, `redirect_pc_o`=EPC. Goes to IDLE.
- `redirect_pc_o` = 0 whenever `redirect_o`=0.
- `busy_o`=1 in FLUSH, VECTOR and RETURN. All inputs are ignored there except for `kill_o`.

## Timing
- Overflow or interrupt sampled at edge T:
  - EPC, Cause and EXL update at T.
  - `flush_o` is high in cycles T+1 and T+2.
  - `redirect_o` is high in cycle T+2.
  - Back in IDLE at T+3.
- `eret` sampled at T: EXL clears at T. `flush_o` and `redirect_o` are high in cycle T+1. IDLE at T+2.
- `kill_o` and `cp0_rdata_o` have zero latency.
- A simultaneous `mtc0` and an accepted event in the same cycle: the event wins, and the `mtc0` write is dropped.
- `mtc0` to Status in cycle T: the new IE takes effect for events sampled at T+1.
- Reset asserted at any point, including mid-FLUSH or mid-VECTOR:
  - State returns to IDLE immediately.
  - All CP0 registers clear.
  - All outputs drop to 0 without waiting for a clock edge.

## Configuration
- `EXC_EXT_INT_EN` defined:
  - `int_i` passes through a 2-flop synchronizer (reset 0) into Cause.IP.
  - Interrupt events are enabled.
  - Assertion to IP=1 takes 2 edges.
- `EXC_EXT_INT_EN` undefined:
  - `int_i` is ignored.
  - IP reads 0.
  - No synchronizer flops exist.
  - IE remains writable but has no effect.

## Test plan
- **Overflow vectoring:** `ovf_i`=1, `ex_valid_i`=1, `pc_ex_i`=32'h0000_0040.
  - `kill_o`=1 in that cycle.
  - Next cycle: EPC=32'h40, Cause[6:2]=12, EXL=1.
  - `flush_o` high for 2 cycles.
  - Redirect to 32'h80 on the second of those cycles.
- **Overflow with EXL=1:** `kill_o`=1, no flush, EPC unchanged.
- **Overflow on a bubble:** `ovf_i`=1 with `ex_valid_i`=0 gives no kill and no event.
- **`eret`:** after the overflow above, `eret_i`=1 → one cycle with `flush_o`=1, `redirect_o`=1, `redirect_pc_o`=32'h40, and EXL=0.
- **Interrupt (`EXC_EXT_INT_EN` defined):**
  - Setup: `mtc0` Status=1, then `int_i`=1, `pc_ex_i`=32'h100.
  - Response: IP=1 after 2 edges, then EPC=32'h100 and ExcCode=0.
  - Same cycle as an overflow: the overflow wins with ExcCode=12.
- **Reset mid-sequence:** drop `rst_n` during VECTOR → `redirect_o`, `flush_o` and `busy_o` go 0 immediately, and Status, Cause and EPC read 0.

Source files
------------

// File: rtl/exc_ctrl.sv
// exc_ctrl: overflow/interrupt exception controller with eret handling
// and the CP0 Status(12)/Cause(13)/EPC(14) registers.
// Ports: clk, rst_n (async, active-low); EX-stage inputs ovf_i, ex_valid_i,
// pc_ex_i, eret_i, mtc0_i, cp0_addr_i, cp0_wdata_i; async int_i.
// Outputs: cp0_rdata_o, kill_o (comb), flush_o, redirect_o,
// redirect_pc_o, busy_o (registered).
// Build option: define EXC_EXT_INT_EN to enable external interrupts.
module exc_ctrl #(
    parameter logic [31:0] HANDLER_ADDR = 32'h0000_0080
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ovf_i,
    input  logic        ex_valid_i,
    input  logic [31:0] pc_ex_i,
    input  logic        eret_i,
    input  logic        int_i,
    input  logic        mtc0_i,
    input  logic [4:0]  cp0_addr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic [31:0] cp0_rdata_o,
    output logic        kill_o,
    output logic        flush_o,
    output logic        redirect_o,
    output logic [31:0] redirect_pc_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FLUSH,
        S_VECTOR,
        S_RETURN
    } state_t;

    state_t      state_q;
    logic        ie_q;
    logic        exl_q;
    logic [4:0]  code_q;
    logic [31:0] epc_q;
    logic        flush_q;
    logic        redir_q;
    logic [31:0] rpc_q;
    logic        busy_q;
    logic        ip;

`ifdef EXC_EXT_INT_EN
    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= int_i;
            sync2_q <= sync1_q;
        end
    end

    assign ip = sync2_q;
`else
    // Interrupt input is ignored; IP is tied low so IE has no effect.
    assign ip = 1'b0 & int_i;
`endif

    logic accept;
    logic ovf_ev;
    logic int_ev;
    logic eret_ev;
    logic mtc0_ev;

    assign accept  = (state_q == S_IDLE) & ex_valid_i;
    assign ovf_ev  = accept & ovf_i & ~exl_q;
    assign int_ev  = accept & ~ovf_ev & ie_q & ~exl_q & ip;
    assign eret_ev = accept & ~ovf_ev & ~int_ev & eret_i;
    assign mtc0_ev = accept & ~ovf_ev & ~int_ev & ~eret_i & mtc0_i;

    // Gated by rst_n so every output is 0 while reset is held.
    assign kill_o = rst_n & ovf_i & ex_valid_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            ie_q    <= 1'b0;
            exl_q   <= 1'b0;
            code_q  <= 5'd0;
            epc_q   <= 32'd0;
            flush_q <= 1'b0;
            redir_q <= 1'b0;
            rpc_q   <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            flush_q <= 1'b0;
            redir_q <= 1'b0;
            rpc_q   <= 32'd0;
            busy_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (ovf_ev | int_ev) begin
                        epc_q   <= pc_ex_i;
                        code_q  <= ovf_ev ? 5'd12 : 5'd0;
                        exl_q   <= 1'b1;
                        state_q <= S_FLUSH;
                        flush_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (eret_ev) begin
                        exl_q   <= 1'b0;
                        state_q <= S_RETURN;
                        flush_q <= 1'b1;
                        redir_q <= 1'b1;
                        rpc_q   <= epc_q;
                        busy_q  <= 1'b1;
                    end else if (mtc0_ev) begin
                        if (cp0_addr_i == 5'd12) begin
                            ie_q  <= cp0_wdata_i[0];
                            exl_q <= cp0_wdata_i[1];
                        end else if (cp0_addr_i == 5'd14) begin
                            epc_q <= cp0_wdata_i;
                        end
                    end
                end
                S_FLUSH: begin
                    state_q <= S_VECTOR;
                    flush_q <= 1'b1;
                    redir_q <= 1'b1;
                    rpc_q   <= HANDLER_ADDR;
                    busy_q  <= 1'b1;
                end
                S_VECTOR, S_RETURN: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign flush_o       = flush_q;
    assign redirect_o    = redir_q;
    assign redirect_pc_o = rpc_q;
    assign busy_o        = busy_q;

    always_comb begin
        cp0_rdata_o = 32'd0;
        case (cp0_addr_i)
            5'd12:   cp0_rdata_o = {30'd0, exl_q, ie_q};
            5'd13:   cp0_rdata_o = {21'd0, ip, 3'd0, code_q, 2'd0};
            5'd14:   cp0_rdata_o = epc_q;
            default: cp0_rdata_o = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: vector table, hand sequences and a randomized run
// against a queue-based reference model of exc_ctrl.
module tb_exc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ovf_i = 1'b0;
    logic        ex_valid_i = 1'b0;
    logic [31:0] pc_ex_i = 32'd0;
    logic        eret_i = 1'b0;
    logic        int_i = 1'b0;
    logic        mtc0_i = 1'b0;
    logic [4:0]  cp0_addr_i = 5'd0;
    logic [31:0] cp0_wdata_i = 32'd0;
    logic [31:0] cp0_rdata_o;
    logic        kill_o;
    logic        flush_o;
    logic        redirect_o;
    logic [31:0] redirect_pc_o;
    logic        busy_o;

    localparam logic [31:0] HADDR = 32'h0000_0080;
`ifdef EXC_EXT_INT_EN
    localparam bit INT_EN = 1'b1;
`else
    localparam bit INT_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    exc_ctrl #(.HANDLER_ADDR(HADDR)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .ovf_i(ovf_i),
        .ex_valid_i(ex_valid_i),
        .pc_ex_i(pc_ex_i),
        .eret_i(eret_i),
        .int_i(int_i),
        .mtc0_i(mtc0_i),
        .cp0_addr_i(cp0_addr_i),
        .cp0_wdata_i(cp0_wdata_i),
        .cp0_rdata_o(cp0_rdata_o),
        .kill_o(kill_o),
        .flush_o(flush_o),
        .redirect_o(redirect_o),
        .redirect_pc_o(redirect_pc_o),
        .busy_o(busy_o)
    );

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic o,
                         input logic [31:0] pc, input logic e,
                         input logic m, input logic [4:0] a,
                         input logic [31:0] wd);
        ex_valid_i  = v;
        ovf_i       = o;
        pc_ex_i     = pc;
        eret_i      = e;
        mtc0_i      = m;
        cp0_addr_i  = a;
        cp0_wdata_i = wd;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        int_i = 1'b0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        v, o, e, m;
        logic [31:0] pc;
        logic [4:0]  a;
        logic [31:0] wd;
        logic        k, f, r;
        logic [31:0] rpc;
        logic        b;
        logic [31:0] rd;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic o,
                                input logic [31:0] pc, input logic e,
                                input logic m, input logic [4:0] a,
                                input logic [31:0] wd, input logic k,
                                input logic f, input logic r,
                                input logic [31:0] rpc, input logic b,
                                input logic [31:0] rd);
        vec_t t;
        t.v = v; t.o = o; t.pc = pc; t.e = e; t.m = m;
        t.a = a; t.wd = wd; t.k = k; t.f = f; t.r = r;
        t.rpc = rpc; t.b = b; t.rd = rd;
        return t;
    endfunction

    // Reference model: CP0 contents plus a queue of pending busy cycles.
    typedef struct {
        logic        f;
        logic        r;
        logic [31:0] pc;
    } out_t;

    out_t        mq[$];
    logic        m_ie, m_exl, h1, h2;
    logic [4:0]  m_code;
    logic [31:0] m_epc;

    function automatic logic m_ip();
        return INT_EN ? h2 : 1'b0;
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        case (a)
            5'd12: return 32'(m_exl) * 2 + 32'(m_ie);
            5'd13: return 32'(m_ip()) * 1024 + 32'(m_code) * 4;
            5'd14: return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    task automatic m_reset();
        mq.delete();
        m_ie = 0; m_exl = 0; h1 = 0; h2 = 0;
        m_code = 0; m_epc = 0;
    endtask

    task automatic m_vector(input logic [4:0] code);
        m_epc  = pc_ex_i;
        m_code = code;
        m_exl  = 1'b1;
        mq.push_back('{1'b1, 1'b0, 32'd0});
        mq.push_back('{1'b1, 1'b1, HADDR});
    endtask

    task automatic m_edge();
        logic ipn;
        ipn = m_ip();
        if (mq.size() > 0) begin
            void'(mq.pop_front());
        end else if (ex_valid_i) begin
            if (ovf_i && !m_exl) m_vector(5'd12);
            else if (m_ie && !m_exl && ipn) m_vector(5'd0);
            else if (eret_i) begin
                m_exl = 1'b0;
                mq.push_back('{1'b1, 1'b1, m_epc});
            end else if (mtc0_i) begin
                if (cp0_addr_i == 5'd12) begin
                    m_ie  = cp0_wdata_i[0];
                    m_exl = cp0_wdata_i[1];
                end else if (cp0_addr_i == 5'd14) begin
                    m_epc = cp0_wdata_i;
                end
            end
        end
        h2 = h1;
        h1 = int_i;
    endtask

    vec_t tbl[$];

    initial begin
        // v o pc e m addr wdata | kill flush redir rpc busy rdata
        tbl.push_back(mk(0,0,0,0,0,12,0,       0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,13,0,       0,0,0,0,0,0));
        tbl.push_back(mk(0,1,'h40,0,0,14,0,    0,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h40,0,0,14,0,    1,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,14,0,       0,1,0,0,1,'h40));
        tbl.push_back(mk(0,0,0,0,0,13,0,       0,1,1,'h80,1,'h30));
        tbl.push_back(mk(0,0,0,0,0,12,0,       0,0,0,0,0,2));
        tbl.push_back(mk(1,1,'h200,0,0,14,0,   1,0,0,0,0,'h40));
        tbl.push_back(mk(0,0,0,0,0,14,0,       0,0,0,0,0,'h40));
        tbl.push_back(mk(1,0,'h48,1,0,12,0,    0,0,0,0,0,2));
        tbl.push_back(mk(0,0,0,0,0,12,0,       0,1,1,'h40,1,0));
        tbl.push_back(mk(0,0,0,0,0,12,0,       0,0,0,0,0,0));
        tbl.push_back(mk(1,0,0,0,1,14,'h1234,  0,0,0,0,0,'h40));
        tbl.push_back(mk(0,0,0,0,0,14,0,       0,0,0,0,0,'h1234));
        tbl.push_back(mk(1,0,0,0,1,13,'hffffffff, 0,0,0,0,0,'h30));
        tbl.push_back(mk(0,0,0,0,0,13,0,       0,0,0,0,0,'h30));
        tbl.push_back(mk(1,0,0,0,1,12,'hffffffff, 0,0,0,0,0,0));
        tbl.push_back(mk(0,0,0,0,0,12,0,       0,0,0,0,0,3));
        tbl.push_back(mk(1,0,0,0,1,12,0,       0,0,0,0,0,3));
        tbl.push_back(mk(0,0,0,0,0,12,0,       0,0,0,0,0,0));
        tbl.push_back(mk(1,1,'h44,0,1,14,'hdead, 1,0,0,0,0,'h1234));
        tbl.push_back(mk(0,0,0,0,0,14,0,       0,1,0,0,1,'h44));
        tbl.push_back(mk(0,0,0,0,0,13,0,       0,1,1,'h80,1,'h30));
        tbl.push_back(mk(0,0,0,0,0,12,0,       0,0,0,0,0,2));

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].o, tbl[i].pc, tbl[i].e, tbl[i].m,
                  tbl[i].a, tbl[i].wd);
            #1;
            chk($sformatf("vec%0d kill", i), 32'(kill_o), 32'(tbl[i].k));
            chk($sformatf("vec%0d flush", i), 32'(flush_o), 32'(tbl[i].f));
            chk($sformatf("vec%0d redir", i), 32'(redirect_o), 32'(tbl[i].r));
            chk($sformatf("vec%0d rpc", i), redirect_pc_o, tbl[i].rpc);
            chk($sformatf("vec%0d busy", i), 32'(busy_o), 32'(tbl[i].b));
            chk($sformatf("vec%0d rdata", i), cp0_rdata_o, tbl[i].rd);
            tick();
        end

        // Asynchronous reset while in VECTOR.
        do_reset();
        drive(1, 1, 32'h60, 0, 0, 14, 0);
        tick();
        drive(0, 0, 0, 0, 0, 14, 0);
        tick();
        #1;
        chk("rst pre redir", 32'(redirect_o), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst redir", 32'(redirect_o), 32'd0);
        chk("rst flush", 32'(flush_o), 32'd0);
        chk("rst busy", 32'(busy_o), 32'd0);
        chk("rst epc", cp0_rdata_o, 32'd0);
        cp0_addr_i = 5'd13;
        #1;
        chk("rst cause", cp0_rdata_o, 32'd0);
        cp0_addr_i = 5'd12;
        #1;
        chk("rst status", cp0_rdata_o, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst after busy", 32'(busy_o), 32'd0);

`ifdef EXC_EXT_INT_EN
        do_reset();
        drive(1, 0, 0, 0, 1, 12, 32'd1);
        tick();
        drive(0, 0, 0, 0, 0, 13, 0);
        int_i = 1'b1;
        #1;
        chk("int ip0", cp0_rdata_o, 32'd0);
        tick();
        chk("int ip1", cp0_rdata_o, 32'd0);
        tick();
        chk("int ip2", cp0_rdata_o, 32'h400);
        drive(1, 0, 32'h100, 0, 0, 14, 0);
        tick();
        drive(0, 0, 0, 0, 0, 14, 0);
        #1;
        chk("int flush", 32'(flush_o), 32'd1);
        chk("int epc", cp0_rdata_o, 32'h100);
        cp0_addr_i = 5'd13;
        #1;
        chk("int cause", cp0_rdata_o, 32'h400);
        tick();
        chk("int vec pc", redirect_pc_o, HADDR);
        tick();
        cp0_addr_i = 5'd12;
        #1;
        chk("int status", cp0_rdata_o, 32'd3);
        drive(1, 0, 32'h180, 1, 0, 12, 0);
        tick();
        drive(0, 0, 0, 0, 0, 12, 0);
        #1;
        chk("int eret pc", redirect_pc_o, 32'h100);
        tick();
        drive(1, 1, 32'h104, 0, 0, 13, 0);
        tick();
        drive(0, 0, 0, 0, 0, 13, 0);
        int_i = 1'b0;
        #1;
        chk("int+ovf cause", cp0_rdata_o, 32'h430);
        cp0_addr_i = 5'd14;
        #1;
        chk("int+ovf epc", cp0_rdata_o, 32'h104);
        tick();
        tick();
`endif

        // Randomized run against the reference model.
        do_reset();
        m_reset();
        for (int c = 0; c < 400; c++) begin
            logic [31:0] r;
            logic [4:0]  a;
            r = $urandom;
            case (r[2:0])
                3'd0: a = 5'd12;
                3'd1, 3'd2: a = 5'd13;
                3'd3, 3'd4: a = 5'd14;
                default: a = 5'($urandom);
            endcase
            drive(r[7:4] != 0, r[10:8] == 0, $urandom & 32'hffff_fffc,
                  r[14:11] == 0, r[17:15] < 2, a, $urandom);
            if (r[22:20] == 0) int_i = ~int_i;
            #1;
            begin
                out_t ex;
                ex = (mq.size() > 0) ? mq[0] : '{1'b0, 1'b0, 32'd0};
                chk($sformatf("rnd%0d kill", c), 32'(kill_o),
                    32'(ex_valid_i && ovf_i));
                chk($sformatf("rnd%0d flush", c), 32'(flush_o), 32'(ex.f));
                chk($sformatf("rnd%0d redir", c), 32'(redirect_o), 32'(ex.r));
                chk($sformatf("rnd%0d rpc", c), redirect_pc_o, ex.pc);
                chk($sformatf("rnd%0d busy", c), 32'(busy_o),
                    32'(mq.size() > 0));
                chk($sformatf("rnd%0d rdata", c), cp0_rdata_o, m_rd(a));
            end
            m_edge();
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
